// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the count_seq block: the FSM state
// encoding, the prescale divider width and the default counter width.
package cnt_seq_pkg;

  localparam int PRESCALE_W    = 8;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_seq_if.sv
// Command channel of count_seq: a valid/ready handshake carrying the start
// value, the terminal count and the direction. When COUNT_SEQ_PRESCALE_EN is
// defined, the channel also carries an 8-bit prescale value.
interface count_seq_if #(
  parameter int WIDTH = cnt_seq_pkg::DEFAULT_WIDTH
);
  import cnt_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;
  logic             cmd_up;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;

  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_up, prescale,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_up, prescale,
    output cmd_ready
  );
`else
  modport master (
    output cmd_valid, cmd_start, cmd_end, cmd_up,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_end, cmd_up,
    output cmd_ready
  );
`endif

endinterface

// File: rtl/cnt_seq_prescaler.sv
// Step divider for count_seq, used only when COUNT_SEQ_PRESCALE_EN is
// defined. The divider is cleared while the counter is being loaded. During
// RUN it counts up and raises tick when it equals the latched limit. On a tick
// it wraps back to 0, so each counter step lasts limit+1 cycles.
module cnt_seq_prescaler
  import cnt_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div;

  // tick is combinational so the counter steps on the same edge the divider wraps
  assign tick = (div == limit);

  // Divider: cleared by reset or during LOAD, advances or wraps during RUN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div <= '0;
    end else if (enable) begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/count_seq.sv
// count_seq: a command-driven up/down counter. When a command is accepted in
// IDLE, the block loads the start value, then steps toward the terminal count
// one step at a time, with modulo 2^WIDTH wrap-around. When the counter reaches
// the terminal count, done pulses for one cycle. An abort in LOAD or RUN
// returns the block to IDLE with the count frozen. Reset is synchronous and
// active high.
// Optional feature: define COUNT_SEQ_PRESCALE_EN to add the prescale field.
// With it, the block steps once every prescale+1 RUN cycles.
module count_seq
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  count_seq_if.slave       cmd,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_t           state;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic             up_q;
  logic             ready_q;
  logic             step_en;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tick;

  cnt_seq_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == LOAD),
    .enable (state == RUN),
    .limit  (prescale_q),
    .tick   (tick)
  );

  assign step_en = tick;

  // Latch the prescale value together with the rest of the command
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
    end else if (state == IDLE && ready_q && cmd.cmd_valid) begin
      prescale_q <= cmd.prescale;
    end
  end
`else
  assign step_en = 1'b1;
`endif

  assign cmd.cmd_ready = ready_q;

  // Sequencer FSM with registered ready/busy/done outputs and the counter register
  always_ff @(posedge clk) begin
    // NOTE: every state register uses <= so all of them update from pre-edge values.
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      start_q <= '0;
      end_q   <= '0;
      up_q    <= 1'b0;
      ready_q <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && ready_q) begin
            start_q <= cmd.cmd_start;
            end_q   <= cmd.cmd_end;
            up_q    <= cmd.cmd_up;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            ready_q <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            count <= start_q;
            state <= RUN;
          end
        end
        RUN: begin
          // abort outranks the terminal-count check
          if (abort) begin
            ready_q <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (count == end_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (step_en) begin
            count <= up_q ? count + 1'b1 : count - 1'b1;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq.sv
// Directed testbench for count_seq. Inputs change on the falling edge, and
// outputs are sampled on the falling edge. Sample index n counts the rising
// edges since the accepting edge, so n = 1 is the sample just after acceptance.
// Define COUNT_SEQ_PRESCALE_EN to include the prescale scenario.
module tb_count_seq;
  import cnt_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] count;

  count_seq_if #(.WIDTH(W)) cmd_if ();

  count_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] cnt_h   [64];
  logic         ready_h [64];
  logic         busy_h  [64];
  int           first_done;
  int           pulses;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample outputs for `window` falling edges, starting with the current one.
  task automatic observe(input int window);
    first_done = 0;
    pulses     = 0;
    for (int n = 1; n <= window; n++) begin
      if (n > 1) @(negedge clk);
      cnt_h[n]   = count;
      ready_h[n] = cmd_if.cmd_ready;
      busy_h[n]  = busy;
      if (done === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = n;
      end
    end
  endtask

  // Called on a falling edge. Offers a command for one rising edge and
  // returns on the next falling edge, which is sample n = 1.
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] e, input logic u);
    check("ready_before_cmd", W'(cmd_if.cmd_ready), W'(1));
    cmd_if.cmd_start = s;
    cmd_if.cmd_end   = e;
    cmd_if.cmd_up    = u;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_start = '0;
    cmd_if.cmd_end   = '0;
    cmd_if.cmd_up    = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
    cmd_if.prescale  = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_count", count, '0);
    check("rst_done", W'(done), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_ready", W'(cmd_if.cmd_ready), W'(1));
    reset = 1'b0;

    // abort in IDLE has no effect
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", W'(cmd_if.cmd_ready), W'(1));
    check("idle_abort_busy", W'(busy), W'(0));
    check("idle_abort_count", count, '0);

    // 5 -> 9 up: d = 4, done at n = 7
    send(32'd5, 32'd9, 1'b1);
    observe(10);
    check("up_latency", W'(first_done), W'(7));
    check("up_pulses", W'(pulses), W'(1));
    for (int k = 0; k < 5; k++) check("up_trace", cnt_h[2+k], W'(5 + k));
    check("up_busy_load", W'(busy_h[2]), W'(1));
    check("up_ready_busy", W'(ready_h[2]), W'(0));
    check("up_busy_done", W'(busy_h[7]), W'(0));
    check("up_ready_after", W'(ready_h[8]), W'(1));
    check("up_hold", cnt_h[10], W'(9));

    // wrap: FFFFFFFE -> 1 up: d = 3, done at n = 6
    send(32'hFFFF_FFFE, 32'd1, 1'b1);
    observe(9);
    check("wrap_latency", W'(first_done), W'(6));
    check("wrap_pulses", W'(pulses), W'(1));
    check("wrap_max", cnt_h[3], 32'hFFFF_FFFF);
    check("wrap_zero", cnt_h[4], 32'd0);
    check("wrap_end", cnt_h[5], 32'd1);

    // start == end: done at n = 3
    send(32'd10, 32'd10, 1'b1);
    observe(6);
    check("eq_latency", W'(first_done), W'(3));
    check("eq_pulses", W'(pulses), W'(1));
    check("eq_count", cnt_h[6], W'(10));

    // abort beats equality: start == end, abort in first RUN cycle (n = 2)
    send(32'd10, 32'd10, 1'b1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    observe(4);
    check("abort_eq_pulses", W'(pulses), W'(0));
    check("abort_eq_ready", W'(ready_h[1]), W'(1));

    // cmd_valid held while busy is ignored: 0 -> 2 up, done at n = 5
    send(32'd0, 32'd2, 1'b1);
    cmd_if.cmd_start = 32'd50;
    cmd_if.cmd_end   = 32'd60;
    cmd_if.cmd_valid = 1'b1;
    observe(4);
    check("ign_no_done_yet", W'(pulses), W'(0));
    check("ign_count_n4", cnt_h[4], W'(2));
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    observe(4);
    check("ign_latency", W'(first_done), W'(1));
    check("ign_pulses", W'(pulses), W'(1));
    check("ign_ready", W'(ready_h[2]), W'(1));
    check("ign_final", cnt_h[4], W'(2));

    // abort in LOAD: count stays at the previous value (2), not loaded with 7
    send(32'd7, 32'd9, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    observe(5);
    check("abort_load_count", cnt_h[1], W'(2));
    check("abort_load_ready", W'(ready_h[1]), W'(1));
    check("abort_load_busy", W'(busy_h[1]), W'(0));
    check("abort_load_pulses", W'(pulses), W'(0));
    check("abort_load_hold", cnt_h[5], W'(2));

    // 20 -> 0 down, abort when count = 15 (n = 7)
    send(32'd20, 32'd0, 1'b0);
    observe(7);
    check("down_first", cnt_h[2], W'(20));
    check("down_at_abort", cnt_h[7], W'(15));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    observe(6);
    check("abort_run_count", cnt_h[1], W'(15));
    check("abort_run_ready", W'(ready_h[1]), W'(1));
    check("abort_run_busy", W'(busy_h[1]), W'(0));
    check("abort_run_pulses", W'(pulses), W'(0));
    check("abort_run_hold", cnt_h[6], W'(15));

    // reset mid-RUN, then a new command on the very next cycle
    send(32'd100, 32'd200, 1'b1);
    observe(5);
    check("pre_reset_count", cnt_h[5], W'(103));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_count", count, '0);
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_busy", W'(busy), W'(0));
    send(32'd3, 32'd4, 1'b1);
    observe(6);
    check("post_rst_busy", W'(busy_h[1]), W'(1));
    check("post_rst_load", cnt_h[2], W'(3));
    check("post_rst_latency", W'(first_done), W'(4));
    check("post_rst_pulses", W'(pulses), W'(1));
    check("post_rst_final", cnt_h[6], W'(4));

`ifdef COUNT_SEQ_PRESCALE_EN
    // prescale 2, 0 -> 2 up: each step 3 cycles, done at n = 9
    cmd_if.prescale = 8'd2;
    send(32'd0, 32'd2, 1'b1);
    cmd_if.prescale = 8'd0;
    observe(12);
    check("ps_latency", W'(first_done), W'(9));
    check("ps_pulses", W'(pulses), W'(1));
    check("ps_hold0", cnt_h[4], W'(0));
    check("ps_step1", cnt_h[5], W'(1));
    check("ps_hold1", cnt_h[7], W'(1));
    check("ps_step2", cnt_h[8], W'(2));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_seq.md
COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the bit width of the counter and of the command values.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 SHALL have port cmd_start, input, WIDTH bits: the value loaded into the counter.
REQ-007 SHALL have port cmd_end, input, WIDTH bits: the terminal count.
REQ-008 SHALL have port cmd_up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-009 SHALL have port abort, input, 1 bit: cancels the sequence in progress.
REQ-010 SHALL have port busy, output, 1 bit: high in states LOAD and RUN.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle pulse when the terminal count is reached.
REQ-012 SHALL have port count, output, WIDTH bits: the current counter value.
REQ-013 SHALL have port prescale, input, 8 bits, present only when COUNT_SEQ_PRESCALE_EN is defined.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-015 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready.
REQ-016 SHALL, on acceptance, latch cmd_start, cmd_end and cmd_up (and prescale, if present), then go IDLE -> LOAD.
REQ-017 SHALL, in LOAD, set count <= start and go LOAD -> RUN.
REQ-018 SHALL, in RUN, go RUN -> DONE with count unchanged when count == end; otherwise count <= count +/- 1 per the latched direction.
REQ-019 SHALL, in DONE, assert done for exactly that one cycle and go DONE -> IDLE; count holds its value in IDLE and DONE.
REQ-020 SHALL wrap the arithmetic modulo 2^WIDTH: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1.
REQ-021 SHALL take d = (end - start) mod 2^WIDTH steps when up, and d = (start - end) mod 2^WIDTH steps when down.
REQ-022 SHALL assert done d+3 cycles after the accepting edge with no prescale; start == end gives done 3 cycles after acceptance.
REQ-023 SHALL, on abort in LOAD or RUN, go to IDLE on the next edge with no done pulse and count frozen at its current value.
REQ-024 SHALL let abort take priority over the equality check in the same cycle.
REQ-025 SHALL ignore abort in IDLE and DONE.
REQ-026 SHALL ignore cmd_valid while cmd_ready = 0; no command is queued.

Reset
REQ-027 SHALL, on reset high at a rising edge, set state = IDLE, count = 0, done = 0, busy = 0, cmd_ready = 1 and clear all latched command registers.
REQ-028 SHALL let reset take priority over all other inputs, including mid-sequence, with no done pulse.

Configuration
REQ-029 SHALL, when COUNT_SEQ_PRESCALE_EN is defined, include the prescale port and an 8-bit divider that is cleared in LOAD.
REQ-030 SHALL, with COUNT_SEQ_PRESCALE_EN defined, step the counter in RUN only when the divider equals the latched prescale value; the divider wraps to 0 on each step.
REQ-031 SHALL, with COUNT_SEQ_PRESCALE_EN defined, check equality every cycle; done latency becomes 3 + d*(P+1) cycles, where P = prescale.
REQ-032 SHALL, without COUNT_SEQ_PRESCALE_EN, omit the port and the divider and step every RUN cycle.

Structure
REQ-033 SHALL place the FSM state enum typedef, the PRESCALE_W = 8 constant and the default WIDTH constant in the shared package cnt_seq_pkg.
REQ-034 SHALL implement the divider as sub-module cnt_seq_prescaler, instantiated only under COUNT_SEQ_PRESCALE_EN; the counter register stays in count_seq.

Verification
REQ-035 SHALL cover: start=5, end=9, up=1 -> count steps 5,6,7,8,9; done pulses once 7 cycles after acceptance; then cmd_ready = 1.
REQ-036 SHALL cover: WIDTH=32, start=0xFFFFFFFE, end=1, up=1 -> count wraps through 0xFFFFFFFF and 0; done after 6 cycles.
REQ-037 SHALL cover: start=10, end=10 -> no step; done 3 cycles after acceptance; count = 10.
REQ-038 SHALL cover: start=20, end=0, up=0, abort asserted when count = 15 -> next cycle IDLE, count = 15, no done.
REQ-039 SHALL cover: reset asserted during RUN -> count = 0, IDLE, done = 0; a new command is accepted on the following cycle.
REQ-040 SHALL cover, with COUNT_SEQ_PRESCALE_EN: prescale=2, start=0, end=2, up=1 -> each step lasts 3 cycles; done 9 cycles after acceptance.
